uart_tx_buf: RTL and testbench



---
 rtl/uart_tx_buf.sv | 104 ++++++++++
 tb/tb_uart_tx_buf.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// Byte-wide transmit FIFO between the CPU store path and the uart sink.
// CPU stores fill the FIFO; bytes drain to the sink at most once every DRAIN_DIV cycles.
module uart_tx_buf #(
    parameter int DEPTH     = 8,
    parameter int DRAIN_DIV = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_cen,
    input  logic        cpu_wr,
    input  logic        cpu_sel,
    input  logic [7:0]  cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        uart_cen,
    output logic        uart_wr,
    output logic [7:0]  uart_wdata,
    output logic        overflow
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PACE_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(DRAIN_DIV - 1);

    logic [7:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PACE_W-1:0] pace_q, pace_d;
    logic              overflow_q, overflow_d;
    logic              uart_cen_q, uart_cen_d;
    logic [7:0]        uart_wdata_q, uart_wdata_d;

    logic push_req, status_wr, full, empty, push_ok, pop;

    always_comb begin
        push_req  = cpu_cen & cpu_wr & ~cpu_sel;
        status_wr = cpu_cen & cpu_wr & cpu_sel;
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        // Fullness uses the pre-edge count, so a same-cycle pop cannot rescue a push.
        push_ok   = push_req & ~full;
        pop       = ~empty & (pace_q == '0);
    end

    always_comb begin
        wr_ptr_d     = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        pace_d       = pace_q;
        if (pop)
            pace_d = PACE_RELOAD;
        else if (pace_q != '0)
            pace_d = pace_q - PACE_W'(1);
        overflow_d   = overflow_q;
        if (status_wr)
            overflow_d = 1'b0;
        else if (push_req && full)
            overflow_d = 1'b1;
        uart_cen_d   = pop;
        uart_wdata_d = pop ? mem_q[rd_ptr_q] : uart_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= cpu_wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pace_q       <= '0;
            overflow_q   <= 1'b0;
            uart_cen_q   <= 1'b0;
            uart_wdata_q <= 8'h00;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pace_q       <= pace_d;
            overflow_q   <= overflow_d;
            uart_cen_q   <= uart_cen_d;
            uart_wdata_q <= uart_wdata_d;
        end
    end

    always_comb begin
        cpu_rdata = 32'h0;
        if (cpu_cen && !cpu_wr && cpu_sel)
            cpu_rdata = {16'h0, 8'(count_q), 5'b0, overflow_q, full, empty};
    end

    assign uart_cen   = uart_cen_q;
    assign uart_wr    = uart_cen_q;
    assign uart_wdata = uart_wdata_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf (DEPTH=8, DRAIN_DIV=4): bytes expected at the sink are
// queued when stored and compared as each strobe appears; timing and status checked directly.
module tb_uart_tx_buf;
    localparam int DEPTH     = 8;
    localparam int DRAIN_DIV = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        cpu_cen = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cpu_sel = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [31:0] cpu_rdata;
    logic        uart_cen;
    logic        uart_wr;
    logic [7:0]  uart_wdata;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int strobe_edges[$];

    uart_tx_buf #(.DEPTH(DEPTH), .DRAIN_DIV(DRAIN_DIV)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_cen(cpu_cen), .cpu_wr(cpu_wr), .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .uart_cen(uart_cen), .uart_wr(uart_wr), .uart_wdata(uart_wdata),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: 0x%08h (edge %0d)", tag, got, cyc);
        end
    endtask

    // Sink side: every strobe must match the oldest byte still expected.
    always @(negedge clk) begin
        if (rstn && uart_cen) begin
            strobe_edges.push_back(cyc);
            check("wr_eq_cen", {31'b0, uart_wr}, 32'd1);
            if (exp_q.size() == 0)
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else
                check("strobe_byte", {24'b0, uart_wdata}, {24'b0, exp_q.pop_front()});
        end
    end

    task automatic do_store(input logic sel, input logic [7:0] d, output int k);
        cpu_cen = 1'b1; cpu_wr = 1'b1; cpu_sel = sel; cpu_wdata = d;
        @(posedge clk); #1;
        k = cyc;
        cpu_cen = 1'b0; cpu_wr = 1'b0; cpu_sel = 1'b0;
    endtask

    task automatic read_reg(input logic sel, output logic [31:0] v);
        cpu_cen = 1'b1; cpu_wr = 1'b0; cpu_sel = sel;
        #1;
        v = cpu_rdata;
        cpu_cen = 1'b0; cpu_sel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_done", 32'(exp_q.size()), 32'd0);
        idle(DRAIN_DIV + 1);
    endtask

    initial begin
        int k, k0, snap;
        logic [31:0] v;

        #3 rstn = 1'b0;
        #1;
        check("rst_uart_cen", {31'b0, uart_cen}, 32'd0);
        check("rst_uart_wr", {31'b0, uart_wr}, 32'd0);
        check("rst_uart_wdata", {24'b0, uart_wdata}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        read_reg(1'b1, v); check("rst_status", v, 32'h0000_0001);
        @(negedge clk); @(negedge clk); #2 rstn = 1'b1;
        idle(2);

        // Single byte: strobe exactly one cycle, one edge after the store.
        strobe_edges.delete();
        exp_q.push_back(8'h41);
        do_store(1'b0, 8'h41, k);
        idle(5);
        check("t1_strobes", 32'(strobe_edges.size()), 32'd1);
        if (strobe_edges.size() > 0) check("t1_edge", strobe_edges[0], k + 1);
        read_reg(1'b1, v); check("t1_status", v, 32'h0000_0001);
        check("t1_wdata_hold", {24'b0, uart_wdata}, 32'h41);
        read_reg(1'b0, v); check("t1_data_read", v, 32'h0);

        // Three consecutive stores drain DRAIN_DIV cycles apart.
        strobe_edges.delete();
        exp_q.push_back(8'h48); do_store(1'b0, 8'h48, k0);
        exp_q.push_back(8'h69); do_store(1'b0, 8'h69, k);
        exp_q.push_back(8'h0A); do_store(1'b0, 8'h0A, k);
        idle(12);
        check("t2_strobes", 32'(strobe_edges.size()), 32'd3);
        for (int i = 0; i < 3 && i < strobe_edges.size(); i++)
            check("t2_edge", strobe_edges[i], k0 + 1 + i * DRAIN_DIV);

        // Fill past capacity: pops at rel. edges 2,6,10 leave 8 queued after edge 11; byte 11 dropped.
        strobe_edges.delete();
        for (int i = 0; i < 12; i++) begin
            if (i <= 10) exp_q.push_back(8'(i));
            do_store(1'b0, 8'(i), k);
            if (i == 0) k0 = k;
            if (i == 10) check("t3_ovf_before", {31'b0, overflow}, 32'd0);
        end
        check("t3_ovf_set", {31'b0, overflow}, 32'd1);
        read_reg(1'b1, v); check("t3_status_full", v, 32'h0000_0806);
        if (strobe_edges.size() > 0) check("t3_first_edge", strobe_edges[0], k0 + 1);

        // STATUS store clears the sticky flag.
        do_store(1'b1, 8'hFF, k);
        check("t4_ovf_clear", {31'b0, overflow}, 32'd0);
        wait_drain();
        read_reg(1'b1, v); check("t4_status_empty", v, 32'h0000_0001);
        snap = strobe_edges.size();
        cpu_cen = 1'b1; cpu_wr = 1'b0; cpu_sel = 1'b0;
        #1 check("t4_data_load", cpu_rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1 cpu_cen = 1'b0;
        read_reg(1'b1, v); check("t4_load_no_effect", v, 32'h0000_0001);
        check("t4_no_strobe", 32'(strobe_edges.size()), 32'(snap));

        // Twenty spaced stores wrap the pointers more than twice.
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            do_store(1'b0, 8'hA0 + 8'(i), k);
            idle(DRAIN_DIV - 1);
        end
        wait_drain();
        check("t5_ovf", {31'b0, overflow}, 32'd0);
        read_reg(1'b1, v); check("t5_status", v, 32'h0000_0001);

        // Reset in the middle of a drain.
        exp_q.push_back(8'h11); do_store(1'b0, 8'h11, k);
        exp_q.push_back(8'h22); do_store(1'b0, 8'h22, k);
        exp_q.push_back(8'h33); do_store(1'b0, 8'h33, k);
        for (int i = 0; i < 20 && !uart_cen; i++) @(negedge clk);
        check("t6_cen_seen", {31'b0, uart_cen}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("t6_cen_async", {31'b0, uart_cen}, 32'd0);
        read_reg(1'b1, v); check("t6_status_rst", v, 32'h0000_0001);
        exp_q.delete();
        snap = strobe_edges.size();
        @(negedge clk); #2 rstn = 1'b1;
        idle(20);
        check("t6_no_strobe", 32'(strobe_edges.size()), 32'(snap));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
